// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI encodings and arbiter state type
package axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Index width for n requesters; never zero so a 1-master build still has a grant bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting after the last winner
module rr_arbiter
    import axi_pkg::*;
#(
    parameter int NumMasters = 2,
    parameter int GrantBits  = idx_bits(NumMasters)
) (
    input  logic [NumMasters-1:0] req,
    input  logic [GrantBits-1:0]  last,
    output logic [GrantBits-1:0]  winner,
    output logic                  any_req
);

    logic [GrantBits-1:0] idx;
    logic                 found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = last;
        for (int off = 0; off < NumMasters; off++) begin
            idx = (idx == GrantBits'(NumMasters - 1)) ? '0 : idx + 1'b1;
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - shares one AXI read slave between NumMasters masters, one burst at a time
module axi_read_arbiter
    import axi_pkg::*;
#(
    parameter int BusWidth   = 32,
    parameter int TagBits    = 4,
    parameter int NumMasters = 2,
    localparam int GrantBits = idx_bits(NumMasters)
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [NumMasters*TagBits-1:0]  M_ARID,
    input  logic [NumMasters*BusWidth-1:0] M_ARADDR,
    input  logic [NumMasters*4-1:0]        M_ARLEN,
    input  logic [NumMasters*2-1:0]        M_ARSIZE,
    input  logic [NumMasters*2-1:0]        M_ARBURST,
    input  logic [NumMasters*2-1:0]        M_ARLOCK,
    input  logic [NumMasters*4-1:0]        M_ARCACHE,
    input  logic [NumMasters*3-1:0]        M_ARPROT,
    input  logic [NumMasters-1:0]          M_ARVALID,
    output logic [NumMasters-1:0]          M_ARREADY,
    output logic [TagBits-1:0]             M_RID,
    output logic [BusWidth-1:0]            M_RDATA,
    output logic [1:0]                     M_RRESP,
    output logic                           M_RLAST,
    output logic [NumMasters-1:0]          M_RVALID,
    input  logic [NumMasters-1:0]          M_RREADY,
    output logic [TagBits-1:0]             S_ARID,
    output logic [BusWidth-1:0]            S_ARADDR,
    output logic [3:0]                     S_ARLEN,
    output logic [1:0]                     S_ARSIZE,
    output logic [1:0]                     S_ARBURST,
    output logic [1:0]                     S_ARLOCK,
    output logic [3:0]                     S_ARCACHE,
    output logic [2:0]                     S_ARPROT,
    output logic                           S_ARVALID,
    input  logic                           S_ARREADY,
    input  logic [TagBits-1:0]             S_RID,
    input  logic [BusWidth-1:0]            S_RDATA,
    input  logic [1:0]                     S_RRESP,
    input  logic                           S_RLAST,
    input  logic                           S_RVALID,
    output logic                           S_RREADY,
    output logic                           busy,
    output logic [GrantBits-1:0]           grant,
    output logic                           protocol_err
);

    arb_state_e           state, state_nxt;
    logic [GrantBits-1:0] last_q;
    logic [GrantBits-1:0] winner;
    logic                 any_req;
    logic [TagBits-1:0]   arid_q;
    logic [3:0]           arlen_q;
    logic [4:0]           beat_q;
    logic                 r_hs;
    logic                 violation;

    rr_arbiter #(
        .NumMasters (NumMasters),
        .GrantBits  (GrantBits)
    ) u_rr (
        .req     (M_ARVALID),
        .last    (last_q),
        .winner  (winner),
        .any_req (any_req)
    );

    // The AR payload follows grant in every state; S_ARVALID alone qualifies it.
    assign S_ARID    = M_ARID[int'(grant)*TagBits +: TagBits];
    assign S_ARADDR  = M_ARADDR[int'(grant)*BusWidth +: BusWidth];
    assign S_ARLEN   = M_ARLEN[int'(grant)*4 +: 4];
    assign S_ARSIZE  = M_ARSIZE[int'(grant)*2 +: 2];
    assign S_ARBURST = M_ARBURST[int'(grant)*2 +: 2];
    assign S_ARLOCK  = M_ARLOCK[int'(grant)*2 +: 2];
    assign S_ARCACHE = M_ARCACHE[int'(grant)*4 +: 4];
    assign S_ARPROT  = M_ARPROT[int'(grant)*3 +: 3];

    assign M_RID   = S_RID;
    assign M_RDATA = S_RDATA;
    assign M_RRESP = S_RRESP;
    assign M_RLAST = S_RLAST;

    assign busy = (state != ST_IDLE);
    assign r_hs = (state == ST_DATA) && S_RVALID && M_RREADY[grant];

    // RLAST must land exactly on beat ARLEN; any beat beyond it without RLAST is also wrong.
    assign violation = (S_RID != arid_q)
                     || (S_RLAST && (beat_q != {1'b0, arlen_q}))
                     || (!S_RLAST && (beat_q > {1'b0, arlen_q}));

    always_comb begin
        state_nxt = state;
        S_ARVALID = 1'b0;
        S_RREADY  = 1'b0;
        M_ARREADY = '0;
        M_RVALID  = '0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                S_ARVALID        = 1'b1;
                M_ARREADY[grant] = S_ARREADY;
                if (S_ARREADY) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                M_RVALID[grant] = S_RVALID;
                S_RREADY        = M_RREADY[grant];
                if (r_hs && S_RLAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state        <= ST_IDLE;
            grant        <= '0;
            last_q       <= GrantBits'(NumMasters - 1);
            arid_q       <= '0;
            arlen_q      <= '0;
            beat_q       <= '0;
            protocol_err <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant   <= winner;
                        arid_q  <= M_ARID[int'(winner)*TagBits +: TagBits];
                        arlen_q <= M_ARLEN[int'(winner)*4 +: 4];
                    end
                end
                ST_ADDR: begin
                    if (S_ARREADY) begin
                        beat_q <= '0;
                    end
                end
                ST_DATA: begin
                    if (r_hs) begin
                        beat_q <= beat_q + 5'd1;
                        if (S_RLAST) begin
                            last_q <= grant;
                        end
                    end
                end
                default: ;
            endcase
            if (r_hs && violation) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - self-checking bench for axi_read_arbiter
module tb_axi_read_arbiter;

    localparam int N = 2;
    localparam int T = 4;
    localparam int W = 32;

    logic           ACLK;
    logic           ARESET;
    logic [N*T-1:0] M_ARID;
    logic [N*W-1:0] M_ARADDR;
    logic [N*4-1:0] M_ARLEN;
    logic [N*2-1:0] M_ARSIZE;
    logic [N*2-1:0] M_ARBURST;
    logic [N*2-1:0] M_ARLOCK;
    logic [N*4-1:0] M_ARCACHE;
    logic [N*3-1:0] M_ARPROT;
    logic [N-1:0]   M_ARVALID;
    logic [N-1:0]   M_ARREADY;
    logic [T-1:0]   M_RID;
    logic [W-1:0]   M_RDATA;
    logic [1:0]     M_RRESP;
    logic           M_RLAST;
    logic [N-1:0]   M_RVALID;
    logic [N-1:0]   M_RREADY;
    logic [T-1:0]   S_ARID;
    logic [W-1:0]   S_ARADDR;
    logic [3:0]     S_ARLEN;
    logic [1:0]     S_ARSIZE;
    logic [1:0]     S_ARBURST;
    logic [1:0]     S_ARLOCK;
    logic [3:0]     S_ARCACHE;
    logic [2:0]     S_ARPROT;
    logic           S_ARVALID;
    logic           S_ARREADY;
    logic [T-1:0]   S_RID;
    logic [W-1:0]   S_RDATA;
    logic [1:0]     S_RRESP;
    logic           S_RLAST;
    logic           S_RVALID;
    logic           S_RREADY;
    logic           busy;
    logic [0:0]     grant;
    logic           protocol_err;

    int tests = 0;
    int fails = 0;

    axi_read_arbiter #(
        .BusWidth   (W),
        .TagBits    (T),
        .NumMasters (N)
    ) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .M_ARID       (M_ARID),
        .M_ARADDR     (M_ARADDR),
        .M_ARLEN      (M_ARLEN),
        .M_ARSIZE     (M_ARSIZE),
        .M_ARBURST    (M_ARBURST),
        .M_ARLOCK     (M_ARLOCK),
        .M_ARCACHE    (M_ARCACHE),
        .M_ARPROT     (M_ARPROT),
        .M_ARVALID    (M_ARVALID),
        .M_ARREADY    (M_ARREADY),
        .M_RID        (M_RID),
        .M_RDATA      (M_RDATA),
        .M_RRESP      (M_RRESP),
        .M_RLAST      (M_RLAST),
        .M_RVALID     (M_RVALID),
        .M_RREADY     (M_RREADY),
        .S_ARID       (S_ARID),
        .S_ARADDR     (S_ARADDR),
        .S_ARLEN      (S_ARLEN),
        .S_ARSIZE     (S_ARSIZE),
        .S_ARBURST    (S_ARBURST),
        .S_ARLOCK     (S_ARLOCK),
        .S_ARCACHE    (S_ARCACHE),
        .S_ARPROT     (S_ARPROT),
        .S_ARVALID    (S_ARVALID),
        .S_ARREADY    (S_ARREADY),
        .S_RID        (S_RID),
        .S_RDATA      (S_RDATA),
        .S_RRESP      (S_RRESP),
        .S_RLAST      (S_RLAST),
        .S_RVALID     (S_RVALID),
        .S_RREADY     (S_RREADY),
        .busy         (busy),
        .grant        (grant),
        .protocol_err (protocol_err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [N-1:0] req;
        int           exp_g;
    } arb_vec_t;

    arb_vec_t tbl[8];
    int       prio_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        ARESET    = 1'b1;
        M_ARID    = '0;
        M_ARADDR  = '0;
        M_ARLEN   = '0;
        M_ARSIZE  = '0;
        M_ARBURST = '0;
        M_ARLOCK  = '0;
        M_ARCACHE = '0;
        M_ARPROT  = '0;
        M_ARVALID = '0;
        M_RREADY  = '0;
        S_ARREADY = 1'b0;
        S_RID     = '0;
        S_RDATA   = '0;
        S_RRESP   = '0;
        S_RLAST   = 1'b0;
        S_RVALID  = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        ARESET = 1'b0;
    endtask

    // Rotating priority list: head is the most favoured master, the last winner sits at the tail.
    task automatic model_reset();
        prio_q = {};
        for (int i = 0; i < N; i++) prio_q.push_back(i);
    endtask

    function automatic int model_pick(input logic [N-1:0] req);
        foreach (prio_q[i]) if (req[prio_q[i]]) return prio_q[i];
        return -1;
    endfunction

    task automatic model_commit(input int g);
        int t;
        while (prio_q[$] != g) begin
            t = prio_q.pop_front();
            prio_q.push_back(t);
        end
    endtask

    // One full burst: request, AR phase with optional wait, R beats until RLAST, turnaround check.
    task automatic run_burst(input logic [N-1:0] req, input int m, input logic [3:0] id,
                             input logic [31:0] addr, input logic [3:0] len, input logic [3:0] rid,
                             input int last_beat, input int ar_wait, input bit toggle,
                             input logic exp_err);
        logic [N-1:0] onehot;
        logic [W-1:0] exp_data;
        int           lat;
        int           b;
        int           guard;
        bit           hs;
        onehot    = '0;
        onehot[m] = 1'b1;
        for (int i = 0; i < N; i++) begin
            M_ARID[i*T +: T]    = (i == m) ? id : ~id;
            M_ARADDR[i*W +: W]  = (i == m) ? addr : ~addr;
            M_ARLEN[i*4 +: 4]   = (i == m) ? len : ~len;
            M_ARBURST[i*2 +: 2] = (i == m) ? 2'b01 : 2'b00;
            M_ARPROT[i*3 +: 3]  = (i == m) ? 3'd5 : 3'd2;
        end
        M_ARVALID = req;
        lat = 0;
        @(negedge ACLK);
        while (!S_ARVALID && lat < 8) begin
            @(posedge ACLK);
            #1;
            @(negedge ACLK);
            lat++;
        end
        check("ar_valid", S_ARVALID, 1);
        if (!S_ARVALID) begin
            M_ARVALID = '0;
            @(posedge ACLK);
            #1;
            return;
        end
        check("ar_latency", lat, 1);
        check("grant", grant, m);
        check("s_araddr", S_ARADDR, addr);
        check("s_arid", S_ARID, id);
        check("s_arlen", S_ARLEN, len);
        check("s_arburst", S_ARBURST, 2'b01);
        check("s_arprot", S_ARPROT, 3'd5);
        for (int w = 0; w < ar_wait; w++) begin
            check("m_arready_wait", M_ARREADY, 0);
            @(posedge ACLK);
            #1;
            @(negedge ACLK);
            check("s_araddr_stable", S_ARADDR, addr);
        end
        S_ARREADY = 1'b1;
        #1;
        check("m_arready", M_ARREADY, onehot);
        @(posedge ACLK);
        #1;
        S_ARREADY = 1'b0;
        M_ARVALID = '0;
        b     = 0;
        guard = 0;
        while (b <= last_beat && guard < 64) begin
            exp_data = (addr + 32'(b) * 4) ^ 32'hA500_0000;
            S_RVALID = 1'b1;
            S_RID    = rid;
            S_RDATA  = exp_data;
            S_RRESP  = 2'b00;
            S_RLAST  = (b == last_beat);
            M_RREADY = toggle ? N'($urandom) : '1;
            hs       = M_RREADY[m];
            @(negedge ACLK);
            check("m_rvalid", M_RVALID, onehot);
            check("s_rready", S_RREADY, hs);
            if (hs) begin
                check("m_rdata", M_RDATA, exp_data);
                check("m_rlast", M_RLAST, b == last_beat);
            end
            @(posedge ACLK);
            #1;
            if (hs) b++;
            guard++;
        end
        S_RVALID = 1'b0;
        S_RLAST  = 1'b0;
        M_RREADY = '0;
        check("r_beats", b, last_beat + 1);
        @(negedge ACLK);
        check("busy_after_last", busy, 0);
        check("turnaround_arvalid", S_ARVALID, 0);
        check("protocol_err", protocol_err, exp_err);
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        logic [N-1:0] req;
        logic [3:0]   id;
        logic [3:0]   len;
        int           m;

        tbl[0] = '{2'b11, 0};
        tbl[1] = '{2'b11, 1};
        tbl[2] = '{2'b01, 0};
        tbl[3] = '{2'b01, 0};
        tbl[4] = '{2'b10, 1};
        tbl[5] = '{2'b11, 0};
        tbl[6] = '{2'b10, 1};
        tbl[7] = '{2'b11, 0};

        do_reset();
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_err", protocol_err, 0);
        check("rst_s_arvalid", S_ARVALID, 0);
        check("rst_s_rready", S_RREADY, 0);
        check("rst_m_arready", M_ARREADY, 0);
        check("rst_m_rvalid", M_RVALID, 0);

        // Slave beats while IDLE are refused and harmless.
        S_RVALID = 1'b1;
        S_RID    = 4'hF;
        S_RLAST  = 1'b1;
        M_RREADY = '1;
        @(negedge ACLK);
        check("idle_s_rready", S_RREADY, 0);
        @(posedge ACLK);
        #1;
        S_RVALID = 1'b0;
        S_RLAST  = 1'b0;
        M_RREADY = '0;
        check("idle_err", protocol_err, 0);

        run_burst(2'b01, 0, 4'h1, 32'h100, 4'd3, 4'h1, 3, 0, 1'b0, 1'b0);

        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_burst(tbl[i].req, tbl[i].exp_g, 4'(i), 32'h1000 + 32'(i) * 32'h40,
                      4'(i % 3), 4'(i), i % 3, 0, 1'b0, 1'b0);
        end

        run_burst(2'b10, 1, 4'h6, 32'h2000, 4'd5, 4'h6, 5, 5, 1'b1, 1'b0);

        do_reset();
        model_reset();
        for (int k = 0; k < 40; k++) begin
            req = N'($urandom_range(1, (1 << N) - 1));
            m   = model_pick(req);
            id  = 4'($urandom);
            len = 4'($urandom_range(0, 7));
            run_burst(req, m, id, $urandom, len, id, int'(len),
                      $urandom_range(0, 3), 1'($urandom), 1'b0);
            model_commit(m);
        end

        run_burst(2'b01, 0, 4'h9, 32'h300, 4'd2, 4'h5, 2, 0, 1'b0, 1'b1);
        run_burst(2'b10, 1, 4'h2, 32'h340, 4'd1, 4'h2, 1, 1, 1'b0, 1'b1);

        do_reset();
        run_burst(2'b01, 0, 4'h4, 32'h400, 4'd3, 4'h4, 1, 0, 1'b0, 1'b1);

        // Reset pulsed after beat 1 of a 4-beat burst held by master 1.
        do_reset();
        M_ARID[T +: T]   = 4'h3;
        M_ARLEN[4 +: 4]  = 4'd3;
        M_ARADDR[W +: W] = 32'h500;
        M_ARVALID        = 2'b10;
        @(posedge ACLK);
        #1;
        S_ARREADY = 1'b1;
        @(posedge ACLK);
        #1;
        S_ARREADY = 1'b0;
        M_ARVALID = '0;
        S_RVALID  = 1'b1;
        S_RID     = 4'h7;
        S_RLAST   = 1'b0;
        M_RREADY  = '1;
        repeat (2) @(posedge ACLK);
        #1;
        check("mid_busy", busy, 1);
        check("mid_grant", grant, 1);
        check("mid_err", protocol_err, 1);
        ARESET = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_grant", grant, 0);
        check("arst_err", protocol_err, 0);
        check("arst_s_rready", S_RREADY, 0);
        check("arst_m_rvalid", M_RVALID, 0);
        check("arst_s_arvalid", S_ARVALID, 0);
        S_RVALID = 1'b0;
        M_RREADY = '0;
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        run_burst(2'b11, 0, 4'hA, 32'h600, 4'd0, 4'hA, 0, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Shares one AXI read slave port between `NumMasters` read masters. Upstream masters issue AR/R traffic into the arbiter; a single AR/R port drives the slave. The arbiter:
- grants the AR channel round-robin;
- allows exactly one outstanding burst at a time;
- steers the R channel back to the granted master;
- flags protocol violations from the slave.

## Interface
Parameters:
- `BusWidth`, 32, address and data width.
- `TagBits`, 4, ID width.
- `NumMasters`, 2, number of upstream masters (2..8).

Ports (upstream buses packed, master i occupies slice i):
- `ACLK` in 1: single clock, all logic on rising edge.
- `ARESET` in 1: asynchronous, active-high reset.
- `M_ARID` in NumMasters*TagBits: per-master ARID.
- `M_ARADDR` in NumMasters*BusWidth: per-master ARADDR.
- `M_ARLEN` in NumMasters*4, `M_ARSIZE` in NumMasters*2, `M_ARBURST` in NumMasters*2: per-master burst controls.
- `M_ARLOCK` in NumMasters*2, `M_ARCACHE` in NumMasters*4, `M_ARPROT` in NumMasters*3: per-master attributes, passed through.
- `M_ARVALID` in NumMasters: per-master address valid.
- `M_ARREADY` out NumMasters: per-master address ready.
- `M_RID` out TagBits, `M_RDATA` out BusWidth, `M_RRESP` out 2, `M_RLAST` out 1: broadcast to all masters, meaningful only to the granted master.
- `M_RVALID` out NumMasters: per-master read valid.
- `M_RREADY` in NumMasters: per-master read ready.
- `S_ARID`, `S_ARADDR`, `S_ARLEN`, `S_ARSIZE`, `S_ARBURST`, `S_ARLOCK`, `S_ARCACHE`, `S_ARPROT` out: muxed AR payload, same widths as one master slice.
- `S_ARVALID` out 1; `S_ARREADY` in 1.
- `S_RID` in TagBits, `S_RDATA` in BusWidth, `S_RRESP` in 2, `S_RLAST` in 1, `S_RVALID` in 1; `S_RREADY` out 1.
- `busy` out 1: state is not IDLE.
- `grant` out clog2(NumMasters): index of the current or last granted master.
- `protocol_err` out 1: sticky violation flag.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - Any `M_ARVALID` set → pick the first requester at or after `last+1` (mod NumMasters), register it in `grant`, latch that master's ARID and ARLEN, go to ADDR.
  - No requester → stay in IDLE.
- ADDR:
  - `S_ARVALID`=1; `S_AR*` = granted master's slice.
  - `M_ARREADY[grant]`=`S_ARREADY`; all other `M_ARREADY` bits = 0.
  - On `S_ARVALID && S_ARREADY` → clear beat counter, go to DATA.
- DATA:
  - `M_RVALID[grant]`=`S_RVALID`; `S_RREADY`=`M_RREADY[grant]`; all other `M_RVALID` bits = 0.
  - Each R handshake increments the beat counter (5 bits).
  - On an R handshake with `S_RLAST` → set `last`=`grant`, go to IDLE.
- Outputs in IDLE: `S_ARVALID`=0, `S_RREADY`=0, all `M_ARREADY`=0, all `M_RVALID`=0.
- `protocol_err` is set on either condition, and cleared only by reset:
  - R handshake with `S_RID` ≠ latched ARID.
  - `S_RLAST` on beat index ≠ latched ARLEN, or a beat past ARLEN without RLAST.
- Requests that drop `M_ARVALID` while not granted are ignored; no request memory.
- `S_RVALID` in IDLE or ADDR is not accepted (`S_RREADY`=0) and does not set `protocol_err`.

## Timing
- Reset values: state IDLE, `grant`=0, `last`=NumMasters-1 (so master 0 wins first), beat counter 0, `protocol_err`=0, `busy`=0. All handshake outputs are 0.
- Arbitration latency: `M_ARVALID` high at edge n → `S_ARVALID` high after edge n+1.
- AR and R handshake outputs are combinational from state and `grant`; the payload mux is combinational from `grant`.
- Burst turnaround: RLAST handshake at edge k → IDLE during cycle k; next `S_ARVALID` no earlier than after edge k+1.
- Back-to-back bursts from one master are permitted only if no other master is requesting.
- `ARESET` asserted mid-burst: immediate return to IDLE with reset values. Slave beats in flight are dropped; the slave must be reset together with the arbiter.

## Structure
- Shared package `axi_pkg`:
  - FSM state encoding (IDLE/ADDR/DATA);
  - AXI burst encodings (FIXED=00, INCR=01, WRAP=10);
  - RRESP encodings.
- Sub-module `rr_arbiter`: combinational round-robin picker. Inputs: request vector, `last` index. Outputs: winner index, any-request flag. Reusable for the planned write-channel arbiter.
- The top level holds the FSM, latched ARID/ARLEN, beat counter, and channel muxes.

## Test plan
- Single request: master 0 requests ARADDR=0x100, ARLEN=3, slave returns 4 beats with RLAST on beat 3 → master 0 receives 4 beats, `protocol_err`=0, `busy` falls after the RLAST edge.
- Contention: masters 0 and 1 request simultaneously, each twice → grant order 0,1,0,1; each AR is issued only after the previous RLAST handshake.
- Backpressure: `S_ARREADY` held low 5 cycles, then `M_RREADY[grant]` toggled during beats → AR payload stable while waiting, no beat lost or duplicated.
- Bad ID: slave returns RID=0x5 for ARID=0x9 → `protocol_err`=1 and stays 1 through later clean bursts.
- Early RLAST: ARLEN=3, RLAST on beat 1 → `protocol_err`=1, FSM returns to IDLE.
- Reset mid-burst: `ARESET` pulsed after beat 1 of 4 → all outputs at reset values within the same cycle; after release, master 0 wins first.
